uart_rx: RTL

Serial receiver that is the counterpart of the CPU's `tx` UART line. It is 8N1, LSB-first, at a fixed baud set by parameter. A 2-flop synchronizer and a mid-bit sampling state machine turn the asynchronous `rx` pin into bytes. Each byte is presented on a valid/ready holding register so the CPU's device interface can take it. It sits beside the transmitter inside `cpu` and is clocked from the same divided system clock.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default frame timing.
// Imported by the receiver, its synchronizer and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS_DEFAULT      = 8;
  localparam int UART_CLOCKS_PER_BIT_DEFAULT = 69;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 3'd0;
  localparam uart_state_t ST_START = 3'd1;
  localparam uart_state_t ST_DATA  = 3'd2;
  localparam uart_state_t ST_STOP  = 3'd3;
  localparam uart_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin, with a chosen reset value.
// Ports: clock, reset (async active-low), d (async in), q (synchronized out).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with mid-bit sampling and valid/ready holding
// register. Ports: clock, reset (async low), rx in; data/valid/ready,
// framing_error pulse, sticky overrun, busy (FSM not idle).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS      = UART_DATA_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [15:0] FULL_M1  = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1  = 16'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 good;
  logic                 hs;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    good    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            good    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it yields a single error.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign hs = valid_q & ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = ov_q;
    if (good) begin
      // A byte taken this cycle frees the register for the new one.
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        if (hs) begin
          ov_d = 1'b0;
        end
      end else begin
        ov_d = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
      ov_d    = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = busy_q;

endmodule
